// File: rtl/dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// dispatch_ctrl
//
// Credit-based flow controller sitting between rename and the combinational
// dispatch crossbar. Each incoming group is classified into INT / MEM / AP
// micro-ops. The group is accepted only when every class fits in the free
// entries (credits) of its issue queue. An accepted group is registered for
// one cycle, so the issue queues can never overflow and need no back-pressure.
// A pipeline flush refills all credits and passes through a one-cycle
// RECOVER state before new groups are taken again.
//
// Optional feature macro:
//   DISPATCH_CTRL_PERF_EN  - when defined, builds three saturating 32-bit
//                            stall counters (one per issue queue). When not
//                            defined, stall_* are tied to zero and no counter
//                            flops exist.
//
// Ports:
//   clock                         rising-edge clock
//   reset                         asynchronous, active-high reset
//   flush                         pipeline flush; all issue queues empty now
//   uop_in[`DISPATCH_WIDTH]       group from rename (per-slot valid/iq_code)
//   in_valid                      group present on uop_in
//   in_ready                      group accepted when in_valid && in_ready
//   uop_out[`DISPATCH_WIDTH]      registered accepted group to the crossbar
//   out_valid                     uop_out holds an accepted group
//   int_ret / mem_ret / ap_ret    entries freed by each queue this cycle
//   int_credit / mem_credit /
//   ap_credit                     current free-entry credit registers
//   stall_int / stall_mem /
//   stall_ap                      perf counters (zero unless PERF_EN)
// ----------------------------------------------------------------------------

`ifndef DISPATCH_WIDTH
`define DISPATCH_WIDTH 4
`endif

`ifndef DISPATCH_CTRL_TYPES_SV
`define DISPATCH_CTRL_TYPES_SV

// Issue-queue class of a micro-op. IQ_NONE never consumes a credit.
typedef enum logic [1:0] {
    IQ_INT  = 2'd0,
    IQ_MEM  = 2'd1,
    IQ_AP   = 2'd2,
    IQ_NONE = 2'd3
} iq_code_t;

// One rename slot. Only valid and iq_code are interpreted here; the rest is
// payload carried through to the crossbar untouched.
typedef struct packed {
    logic       valid;
    iq_code_t   iq_code;
    logic [5:0] rob_tag;
    logic [7:0] opcode;
} micro_op_t;

`endif

module dispatch_ctrl #(
    // Each depth must be at least `DISPATCH_WIDTH so a credit register can
    // represent a full group.
    parameter int  INT_IQ_DEPTH = 16,
    parameter int  MEM_IQ_DEPTH = 16,
    parameter int  AP_IQ_DEPTH  = 16,
    localparam int CW           = $clog2(`DISPATCH_WIDTH + 1),
    localparam int INT_CRW      = $clog2(INT_IQ_DEPTH + 1),
    localparam int MEM_CRW      = $clog2(MEM_IQ_DEPTH + 1),
    localparam int AP_CRW       = $clog2(AP_IQ_DEPTH + 1)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                flush,
    input  micro_op_t [`DISPATCH_WIDTH-1:0]     uop_in,
    input  logic                                in_valid,
    output logic                                in_ready,
    output micro_op_t [`DISPATCH_WIDTH-1:0]     uop_out,
    output logic                                out_valid,
    input  logic [CW-1:0]                       int_ret,
    input  logic [CW-1:0]                       mem_ret,
    input  logic [CW-1:0]                       ap_ret,
    output logic [INT_CRW-1:0]                  int_credit,
    output logic [MEM_CRW-1:0]                  mem_credit,
    output logic [AP_CRW-1:0]                   ap_credit,
    output logic [31:0]                         stall_int,
    output logic [31:0]                         stall_mem,
    output logic [31:0]                         stall_ap
);

    typedef enum logic {
        S_RUN     = 1'b0,
        S_RECOVER = 1'b1
    } state_t;

    state_t state;

    // ------------------------------------------------------------------
    // Per-class population count of the incoming group.
    // ------------------------------------------------------------------
    function automatic logic [CW-1:0] count_class(
        input micro_op_t [`DISPATCH_WIDTH-1:0] grp,
        input iq_code_t                        code
    );
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < `DISPATCH_WIDTH; i++) begin
            if (grp[i].valid && (grp[i].iq_code == code))
                n = n + CW'(1);
        end
        return n;
    endfunction

    logic [CW-1:0] n_int, n_mem, n_ap;
    logic          int_fit, mem_fit, ap_fit;
    logic          accept;

    assign n_int = count_class(uop_in, IQ_INT);
    assign n_mem = count_class(uop_in, IQ_MEM);
    assign n_ap  = count_class(uop_in, IQ_AP);

    // Only the registered credit is compared: returns arriving this cycle are
    // deliberately not forwarded, which keeps in_ready off the *_ret paths.
    assign int_fit = INT_CRW'(n_int) <= int_credit;
    assign mem_fit = MEM_CRW'(n_mem) <= mem_credit;
    assign ap_fit  = AP_CRW'(n_ap)   <= ap_credit;

    // Flush wins over a fitting group; RECOVER never accepts.
    assign in_ready = (state == S_RUN) && int_fit && mem_fit && ap_fit && !flush;
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // Next-credit arithmetic, one bit wider than the register so an
    // over-return shows up as a value above the depth instead of wrapping.
    // ------------------------------------------------------------------
    logic [INT_CRW:0] int_next;
    logic [MEM_CRW:0] mem_next;
    logic [AP_CRW:0]  ap_next;

    // NOTE: every always_comb output gets a default on entry so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        int_next = {1'b0, int_credit} + (INT_CRW+1)'(int_ret);
        mem_next = {1'b0, mem_credit} + (MEM_CRW+1)'(mem_ret);
        ap_next  = {1'b0, ap_credit}  + (AP_CRW+1)'(ap_ret);
        if (accept) begin
            int_next = int_next - (INT_CRW+1)'(n_int);
            mem_next = mem_next - (MEM_CRW+1)'(n_mem);
            ap_next  = ap_next  - (AP_CRW+1)'(n_ap);
        end
    end

    // ------------------------------------------------------------------
    // Control FSM with registered credits and output group.
    // ------------------------------------------------------------------
    // NOTE: sequential state is written only with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_RUN;
            int_credit <= INT_CRW'(INT_IQ_DEPTH);
            mem_credit <= MEM_CRW'(MEM_IQ_DEPTH);
            ap_credit  <= AP_CRW'(AP_IQ_DEPTH);
            uop_out    <= '0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            // Queues are emptied this cycle: refill credits, drop returns and
            // the incoming group, and spend one cycle in RECOVER.
            state      <= S_RECOVER;
            int_credit <= INT_CRW'(INT_IQ_DEPTH);
            mem_credit <= MEM_CRW'(MEM_IQ_DEPTH);
            ap_credit  <= AP_CRW'(AP_IQ_DEPTH);
            uop_out    <= '0;
            out_valid  <= 1'b0;
        end else if (state == S_RECOVER) begin
            // Returns during RECOVER belong to flushed entries; ignore them.
            state      <= S_RUN;
            uop_out    <= '0;
            out_valid  <= 1'b0;
        end else begin
            state      <= S_RUN;
            int_credit <= int_next[INT_CRW-1:0];
            mem_credit <= mem_next[MEM_CRW-1:0];
            ap_credit  <= ap_next[AP_CRW-1:0];
            uop_out    <= accept ? uop_in : '0;
            out_valid  <= accept;
        end
    end

    // ------------------------------------------------------------------
    // Optional stall counters.
    // ------------------------------------------------------------------
`ifdef DISPATCH_CTRL_PERF_EN
    logic stall_window;
    assign stall_window = (state == S_RUN) && in_valid && !flush;

    // Cleared by reset only; a flush leaves the history intact.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_int <= '0;
            stall_mem <= '0;
            stall_ap  <= '0;
        end else begin
            if (stall_window && !int_fit && (stall_int != '1))
                stall_int <= stall_int + 32'd1;
            if (stall_window && !mem_fit && (stall_mem != '1))
                stall_mem <= stall_mem + 32'd1;
            if (stall_window && !ap_fit && (stall_ap != '1))
                stall_ap <= stall_ap + 32'd1;
        end
    end
`else
    assign stall_int = '0;
    assign stall_mem = '0;
    assign stall_ap  = '0;
`endif

    // ------------------------------------------------------------------
    // Protocol and invariant checks.
    // ------------------------------------------------------------------
    // Returns must never push a credit above the queue depth.
    a_int_max: assert property (@(posedge clock) disable iff (reset)
        ((state == S_RUN) && !flush) |-> (int_next <= (INT_CRW+1)'(INT_IQ_DEPTH)));
    a_mem_max: assert property (@(posedge clock) disable iff (reset)
        ((state == S_RUN) && !flush) |-> (mem_next <= (MEM_CRW+1)'(MEM_IQ_DEPTH)));
    a_ap_max:  assert property (@(posedge clock) disable iff (reset)
        ((state == S_RUN) && !flush) |-> (ap_next <= (AP_CRW+1)'(AP_IQ_DEPTH)));

    // An accepted group never takes more than the registered credit.
    a_int_under: assert property (@(posedge clock) disable iff (reset)
        accept |-> ((INT_CRW+1)'(n_int) <= {1'b0, int_credit}));
    a_mem_under: assert property (@(posedge clock) disable iff (reset)
        accept |-> ((MEM_CRW+1)'(n_mem) <= {1'b0, mem_credit}));
    a_ap_under:  assert property (@(posedge clock) disable iff (reset)
        accept |-> ((AP_CRW+1)'(n_ap) <= {1'b0, ap_credit}));

    // Rename holds a stalled group unchanged until it is taken (a flush or a
    // withdrawn in_valid releases it).
    a_stable: assert property (@(posedge clock) disable iff (reset)
        ((state == S_RUN) && in_valid && !in_ready && !flush)
        |=> (flush || !in_valid || (uop_in == $past(uop_in))));

endmodule

// File: tb/tb_dispatch_ctrl.sv
// ----------------------------------------------------------------------------
// tb_dispatch_ctrl
//
// Directed bench for dispatch_ctrl. Inputs change 1 time unit after each
// rising edge; registered outputs are read at that point, and the
// combinational in_ready is read 1 unit later once the new inputs settle.
// Expected values are hand-computed credit arithmetic.
// ----------------------------------------------------------------------------

module tb_dispatch_ctrl;

    localparam int W = `DISPATCH_WIDTH;

`ifdef DISPATCH_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              reset;
    logic              flush;
    micro_op_t [W-1:0] uop_in;
    logic              in_valid;
    logic              in_ready;
    micro_op_t [W-1:0] uop_out;
    logic              out_valid;
    logic [2:0]        int_ret, mem_ret, ap_ret;
    logic [4:0]        int_credit, mem_credit, ap_credit;
    logic [31:0]       stall_int, stall_mem, stall_ap;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    dispatch_ctrl dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .uop_in     (uop_in),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .uop_out    (uop_out),
        .out_valid  (out_valid),
        .int_ret    (int_ret),
        .mem_ret    (mem_ret),
        .ap_ret     (ap_ret),
        .int_credit (int_credit),
        .mem_credit (mem_credit),
        .ap_credit  (ap_credit),
        .stall_int  (stall_int),
        .stall_mem  (stall_mem),
        .stall_ap   (stall_ap)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic micro_op_t op(input iq_code_t c, input logic [5:0] tag);
        micro_op_t u;
        u.valid   = 1'b1;
        u.iq_code = c;
        u.rob_tag = tag;
        u.opcode  = 8'h80 | {2'b00, tag};
        return u;
    endfunction

    function automatic micro_op_t nop;
        return '0;
    endfunction

    function automatic logic [W-1:0] valid_bits(input micro_op_t [W-1:0] g);
        logic [W-1:0] v;
        for (int i = 0; i < W; i++) v[i] = g[i].valid;
        return v;
    endfunction

    micro_op_t [W-1:0] grp_a, grp_b, grp_c, grp_d, grp_e, grp_z, grp_f;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        flush    = 1'b0;
        uop_in   = '0;
        in_valid = 1'b0;
        int_ret  = '0;
        mem_ret  = '0;
        ap_ret   = '0;

        // ---------------- reset state ----------------
        #12;
        check("rst_out_valid", 128'(out_valid), 128'(1'b0));
        check("rst_uop_out", 128'(uop_out), 128'(0));
        check("rst_int_credit", 128'(int_credit), 128'(5'd16));
        check("rst_mem_credit", 128'(mem_credit), 128'(5'd16));
        check("rst_ap_credit", 128'(ap_credit), 128'(5'd16));
        check("rst_stall_int", 128'(stall_int), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1'b1));
        @(negedge clock);
        reset = 1'b0;
        tick();

        // ---------------- first group {INT,INT,MEM,AP} ----------------
        grp_a    = {op(IQ_AP, 6'd3), op(IQ_MEM, 6'd2), op(IQ_INT, 6'd1), op(IQ_INT, 6'd0)};
        uop_in   = grp_a;
        in_valid = 1'b1;
        #1;
        check("a_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("a_out_valid", 128'(out_valid), 128'(1'b1));
        check("a_uop_out", 128'(uop_out), 128'(grp_a));
        check("a_int_credit", 128'(int_credit), 128'(5'd14));
        check("a_mem_credit", 128'(mem_credit), 128'(5'd15));
        check("a_ap_credit", 128'(ap_credit), 128'(5'd15));

        // Return everything the first group took: back to 16/16/16.
        in_valid = 1'b0;
        uop_in   = '0;
        int_ret  = 3'd2;
        mem_ret  = 3'd1;
        ap_ret   = 3'd1;
        tick();
        int_ret = '0;
        mem_ret = '0;
        ap_ret  = '0;
        check("idle_out_valid", 128'(out_valid), 128'(1'b0));
        check("idle_uop_out", 128'(uop_out), 128'(0));
        check("ret_int_credit", 128'(int_credit), 128'(5'd16));
        check("ret_mem_credit", 128'(mem_credit), 128'(5'd16));

        // ---------------- drain INT to exactly zero ----------------
        for (int g = 0; g < 4; g++) begin
            uop_in = {op(IQ_INT, 6'(4*g+3)), op(IQ_INT, 6'(4*g+2)),
                      op(IQ_INT, 6'(4*g+1)), op(IQ_INT, 6'(4*g))};
            in_valid = 1'b1;
            #1;
            check("drain_in_ready", 128'(in_ready), 128'(1'b1));
            tick();
        end
        check("drain_int_credit", 128'(int_credit), 128'(5'd0));

        // {INT,MEM,-,-} stalls on INT (stall cycle 1 of 2 for stall_int).
        grp_b  = {nop(), nop(), op(IQ_MEM, 6'd21), op(IQ_INT, 6'd20)};
        uop_in = grp_b;
        #1;
        check("zero_int_stall", 128'(in_ready), 128'(1'b0));
        tick();
        check("stall_out_valid", 128'(out_valid), 128'(1'b0));
        // A return this cycle is not forwarded (stall cycle 2 of 2).
        int_ret = 3'd1;
        #1;
        check("no_forward", 128'(in_ready), 128'(1'b0));
        tick();
        int_ret = '0;
        check("ret1_int_credit", 128'(int_credit), 128'(5'd1));
        #1;
        check("ret1_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("b_out_valid", 128'(out_valid), 128'(1'b1));
        check("b_uop_out", 128'(uop_out), 128'(grp_b));
        check("b_int_credit", 128'(int_credit), 128'(5'd0));
        check("b_mem_credit", 128'(mem_credit), 128'(5'd15));

        // With INT credit zero, a group without INT still passes.
        grp_c  = {nop(), nop(), op(IQ_AP, 6'd23), op(IQ_MEM, 6'd22)};
        uop_in = grp_c;
        #1;
        check("c_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("c_mem_credit", 128'(mem_credit), 128'(5'd14));
        check("c_ap_credit", 128'(ap_credit), 128'(5'd15));

        // ---------------- same-cycle accept and return ----------------
        in_valid = 1'b0;
        uop_in   = '0;
        int_ret  = 3'd2;
        tick();
        int_ret = '0;
        check("pre_d_int_credit", 128'(int_credit), 128'(5'd2));
        grp_d    = {nop(), nop(), op(IQ_INT, 6'd25), op(IQ_INT, 6'd24)};
        uop_in   = grp_d;
        in_valid = 1'b1;
        int_ret  = 3'd3;
        #1;
        check("d_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        int_ret = '0;
        check("d_int_credit", 128'(int_credit), 128'(5'd3));   // 2 - 2 + 3

        // ---------------- flush with a fitting group ----------------
        in_valid = 1'b0;
        uop_in   = '0;
        int_ret  = 3'd2;
        tick();
        int_ret = '0;
        check("pre_e_int_credit", 128'(int_credit), 128'(5'd5));
        grp_e    = {nop(), nop(), nop(), op(IQ_INT, 6'd26)};
        uop_in   = grp_e;
        in_valid = 1'b1;
        flush    = 1'b1;
        #1;
        check("flush_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        flush   = 1'b0;
        int_ret = 3'd1;                                        // ignored in RECOVER
        check("flush_out_valid", 128'(out_valid), 128'(1'b0));
        check("flush_int_credit", 128'(int_credit), 128'(5'd16));
        check("flush_mem_credit", 128'(mem_credit), 128'(5'd16));
        check("flush_ap_credit", 128'(ap_credit), 128'(5'd16));
        #1;
        check("recover_in_ready", 128'(in_ready), 128'(1'b0));
        tick();
        int_ret = '0;
        check("recover_out_valid", 128'(out_valid), 128'(1'b0));
        check("recover_ret_ignored", 128'(int_credit), 128'(5'd16));
        #1;
        check("run_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("e_out_valid", 128'(out_valid), 128'(1'b1));
        check("e_uop_out", 128'(uop_out), 128'(grp_e));
        check("e_int_credit", 128'(int_credit), 128'(5'd15));

        // ---------------- empty group ----------------
        grp_z = '0;
        for (int i = 0; i < W; i++) begin
            grp_z[i].rob_tag = 6'(30 + i);
            grp_z[i].iq_code = IQ_MEM;
        end
        uop_in = grp_z;
        #1;
        check("z_in_ready", 128'(in_ready), 128'(1'b1));
        tick();
        check("z_out_valid", 128'(out_valid), 128'(1'b1));
        check("z_slots_valid", 128'(valid_bits(uop_out)), 128'(4'b0000));
        check("z_uop_out", 128'(uop_out), 128'(grp_z));
        check("z_int_credit", 128'(int_credit), 128'(5'd15));
        check("z_mem_credit", 128'(mem_credit), 128'(5'd16));
        check("z_ap_credit", 128'(ap_credit), 128'(5'd16));
        check("int_stalls", 128'(stall_int), PERF ? 128'(2) : 128'(0));

        // ---------------- asynchronous reset mid-operation ----------------
        in_valid = 1'b0;
        uop_in   = '0;
        #2;
        reset = 1'b1;
        #1;
        check("async_out_valid", 128'(out_valid), 128'(1'b0));
        check("async_int_credit", 128'(int_credit), 128'(5'd16));
        check("async_stall_int", 128'(stall_int), 128'(0));
        @(negedge clock);
        reset = 1'b0;
        tick();

        // ---------------- MEM stall counting ----------------
        for (int g = 0; g < 3; g++) begin
            uop_in   = {op(IQ_MEM, 6'(4*g+3)), op(IQ_MEM, 6'(4*g+2)),
                        op(IQ_MEM, 6'(4*g+1)), op(IQ_MEM, 6'(4*g))};
            in_valid = 1'b1;
            tick();
        end
        uop_in = {nop(), nop(), op(IQ_MEM, 6'd13), op(IQ_MEM, 6'd12)};
        tick();
        check("pre_f_mem_credit", 128'(mem_credit), 128'(5'd2));
        grp_f  = {op(IQ_MEM, 6'd43), op(IQ_MEM, 6'd42), op(IQ_MEM, 6'd41), op(IQ_MEM, 6'd40)};
        uop_in = grp_f;
        #1;
        check("f_in_ready", 128'(in_ready), 128'(1'b0));
        for (int c = 0; c < 10; c++) tick();
        in_valid = 1'b0;
        uop_in   = '0;
        check("stall_mem", 128'(stall_mem), PERF ? 128'(10) : 128'(0));
        check("stall_int_zero", 128'(stall_int), 128'(0));
        check("stall_ap_zero", 128'(stall_ap), 128'(0));
        check("f_mem_credit", 128'(mem_credit), 128'(5'd2));

        // A flush leaves the counters alone.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("flush_keeps_stall", 128'(stall_mem), PERF ? 128'(10) : 128'(0));
        check("post_flush_mem", 128'(mem_credit), 128'(5'd16));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
